// File: rtl/mac_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, filters destination MAC, checks FCS and
// delivers frame bytes (FCS removed) with last/good markers and good/bad frame counters.
module mac_rx_frame_checker #(
  parameter logic [47:0] LOCAL_MAC     = 48'h00D0_0800_0002,
  parameter bit          CHECK_DST_MAC = 1'b1,
  parameter int unsigned MIN_FRAME     = 64,
  parameter int unsigned MAX_FRAME     = 1518
) (
  input  logic        gmii_clk_in,
  input  logic        gmii_rst_in,
  input  logic [7:0]  gmii_rxd_in,
  input  logic        gmii_rx_dv_in,
  input  logic        gmii_rx_er_in,
  output logic [7:0]  mac_rdata_out,
  output logic        mac_rvalid_out,
  output logic        mac_rlast_out,
  output logic        mac_rgood_out,
  output logic [15:0] frame_good_cnt_out,
  output logic [15:0] frame_bad_cnt_out
);

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;
  localparam logic [10:0] MinCnt     = 11'(MIN_FRAME);
  localparam logic [10:0] MaxCnt     = 11'(MAX_FRAME);

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      pre_cnt_q, pre_cnt_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic [4:0][7:0] dly_q, dly_d;
  logic            err_q, err_d;
  logic            match_local_q, match_local_d;
  logic            match_bcast_q, match_bcast_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic            rgood_q, rgood_d;
  logic [15:0]     good_cnt_q, good_cnt_d;
  logic [15:0]     bad_cnt_q, bad_cnt_d;

  logic [7:0] mac_byte;
  logic       mac_ok;
  logic       full;
  logic       frame_ok;

  always_comb begin
    case (byte_cnt_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
  end

  // Byte 5 is still on the input, so the destination decision folds it in combinationally.
  assign mac_ok   = (match_local_q && (gmii_rxd_in == mac_byte)) ||
                    (match_bcast_q && (gmii_rxd_in == 8'hFF));
  assign full     = (byte_cnt_q >= 11'd5);
  assign frame_ok = (crc_q == CrcResidue) && (byte_cnt_q >= MinCnt) &&
                    (byte_cnt_q <= MaxCnt) && !err_q;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    crc_d         = crc_q;
    dly_d         = dly_q;
    err_d         = err_q;
    match_local_d = match_local_q;
    match_bcast_d = match_bcast_q;
    rdata_d       = 8'h00;
    rvalid_d      = 1'b0;
    rlast_d       = 1'b0;
    rgood_d       = 1'b0;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (gmii_rx_dv_in) begin
          if (gmii_rxd_in == 8'h55) begin
            state_d   = StPreamble;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!gmii_rx_dv_in) begin
          state_d = StIdle;
        end else if (gmii_rxd_in == 8'h55) begin
          if (pre_cnt_q >= 4'd7) state_d = StDrop;
          else                   pre_cnt_d = pre_cnt_q + 4'd1;
        end else if ((gmii_rxd_in == 8'hD5) && (pre_cnt_q >= 4'd1) && (pre_cnt_q <= 4'd7)) begin
          state_d       = StData;
          byte_cnt_d    = '0;
          crc_d         = '1;
          dly_d         = '0;
          err_d         = 1'b0;
          match_local_d = 1'b1;
          match_bcast_d = 1'b1;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!gmii_rx_dv_in) begin
          state_d = StIdle;
          if (full) begin
            rdata_d  = dly_q[4];
            rvalid_d = 1'b1;
            rlast_d  = 1'b1;
            rgood_d  = frame_ok;
            if (frame_ok) good_cnt_d = good_cnt_q + 16'd1;
            else          bad_cnt_d  = bad_cnt_q + 16'd1;
          end else begin
            bad_cnt_d = bad_cnt_q + 16'd1;
          end
        end else if (byte_cnt_q == MaxCnt) begin
          state_d   = StDrop;
          rdata_d   = dly_q[4];
          rvalid_d  = 1'b1;
          rlast_d   = 1'b1;
          bad_cnt_d = bad_cnt_q + 16'd1;
        end else if (CHECK_DST_MAC && (byte_cnt_q == 11'd5) && !mac_ok) begin
          state_d = StDrop;
        end else begin
          dly_d      = {dly_q[3:0], gmii_rxd_in};
          crc_d      = crc_byte(crc_q, gmii_rxd_in);
          byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
          err_d      = err_q | gmii_rx_er_in;
          if (byte_cnt_q < 11'd6) begin
            match_local_d = match_local_q && (gmii_rxd_in == mac_byte);
            match_bcast_d = match_bcast_q && (gmii_rxd_in == 8'hFF);
          end
          if (full) begin
            rdata_d  = dly_q[4];
            rvalid_d = 1'b1;
          end
        end
      end
      StDrop: begin
        if (!gmii_rx_dv_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gmii_clk_in or posedge gmii_rst_in) begin
    if (gmii_rst_in) begin
      state_q       <= StIdle;
      pre_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      crc_q         <= '1;
      dly_q         <= '0;
      err_q         <= 1'b0;
      match_local_q <= 1'b0;
      match_bcast_q <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rgood_q       <= 1'b0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      crc_q         <= crc_d;
      dly_q         <= dly_d;
      err_q         <= err_d;
      match_local_q <= match_local_d;
      match_bcast_q <= match_bcast_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      rlast_q       <= rlast_d;
      rgood_q       <= rgood_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
    end
  end

  assign mac_rdata_out      = rdata_q;
  assign mac_rvalid_out     = rvalid_q;
  assign mac_rlast_out      = rlast_q;
  assign mac_rgood_out      = rgood_q;
  assign frame_good_cnt_out = good_cnt_q;
  assign frame_bad_cnt_out  = bad_cnt_q;

endmodule
